// File: rtl/mul_pkg.sv
//------------------------------------------------------------------------------
// Module : mul_pkg
// Brief  : Shared types and sizing helpers for the digit-serial multiplier.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package mul_pkg;

    // Controller states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of one operand digit handled by the shared cell
    localparam int DIGIT_W = 2;

    // Number of 2-bit digits in a WIDTH-bit operand
    function automatic int num_digits(input int width);
        return width / DIGIT_W;
    endfunction

    // Index width for a digit counter; never narrower than one bit
    function automatic int idx_width(input int digits);
        return (digits <= 1) ? 1 : $clog2(digits);
    endfunction

endpackage : mul_pkg

`default_nettype wire

// File: rtl/mul_2x2.sv
//------------------------------------------------------------------------------
// Module : mul_2x2
// Brief  : Combinational 2-bit x 2-bit unsigned multiplier cell.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mul_2x2 (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);

    // Operands are widened first so the 4-bit product (max 9) is never truncated
    assign o_p = {2'b00, i_a} * {2'b00, i_b};

endmodule : mul_2x2

`default_nettype wire

// File: rtl/mul_2x2_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : mul_2x2_seq_ctrl
// Brief  : Digit-serial unsigned WIDTH x WIDTH multiplier. One shared 2x2 cell
//          is stepped over every digit pair; shifted partial products are
//          summed into a 2*WIDTH accumulator. Fixed latency of D*D cycles.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mul_2x2_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int D  = num_digits(WIDTH);
    localparam int IW = idx_width(D);
    localparam int PW = 2 * WIDTH;
    localparam logic [IW-1:0] c_LAST_IDX = IW'(D - 1);

    state_e             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_product;
    logic [IW-1:0]      r_i;
    logic [IW-1:0]      r_j;

    logic [1:0]         w_a_dig;
    logic [1:0]         w_b_dig;
    logic [3:0]         w_pp;
    logic [IW:0]        w_ij;
    logic [PW-1:0]      w_pp_shift;
    logic [PW-1:0]      w_acc_next;
    logic               w_last;

    // Select the current digit pair: digit k lives at bits [2k+1:2k]
    assign w_a_dig = 2'(r_a >> {r_i, 1'b0});
    assign w_b_dig = 2'(r_b >> {r_j, 1'b0});

    mul_2x2 u_cell (
        .i_a (w_a_dig),
        .i_b (w_b_dig),
        .o_p (w_pp)
    );

    // Weight of the partial product is 4^(i+j); sum carries one extra bit
    assign w_ij       = {1'b0, r_i} + {1'b0, r_j};
    assign w_pp_shift = PW'(w_pp) << {w_ij, 1'b0};
    assign w_acc_next = r_acc + w_pp_shift;
    assign w_last     = (r_i == c_LAST_IDX) && (r_j == c_LAST_IDX);

    // Handshake outputs decode from state only, keeping in->out paths registered
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign product   = r_product;

    // Controller FSM with operand capture, digit stepping and accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_i       <= '0;
            r_j       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        // Final step: publish the completed sum
                        r_product <= w_acc_next;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_state   <= DONE;
                    end else if (r_j == c_LAST_IDX) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mul_2x2_seq_ctrl

`default_nettype wire

// File: tb/tb_mul_2x2_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_mul_2x2_seq_ctrl
// Brief  : Self-checking bench for mul_2x2_seq_ctrl at WIDTH=8 and WIDTH=2,
//          using per-instance scoreboard queues of expected products.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mul_2x2_seq_ctrl;

    logic        clk;
    logic        rst;

    // WIDTH=8 instance signals
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] product8;
    logic        busy8;

    // WIDTH=2 instance signals
    logic        in_valid2;
    logic        in_ready2;
    logic [1:0]  a2;
    logic [1:0]  b2;
    logic        out_valid2;
    logic        out_ready2;
    logic [3:0]  product2;
    logic        busy2;

    logic [15:0] q8[$];
    logic [3:0]  q2[$];

    int n_cmp;
    int n_err;

    mul_2x2_seq_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8),
        .busy      (busy8)
    );

    mul_2x2_seq_ctrl #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .product   (product2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair to the WIDTH=8 instance (assumed IDLE) and log it
    task automatic send8(input logic [7:0] av, input logic [7:0] bv);
        a8        = av;
        b8        = bv;
        in_valid8 = 1'b1;
        q8.push_back(16'(av) * 16'(bv));
        tick();
        in_valid8 = 1'b0;
    endtask

    // Cycles from the sample after acceptance until out_valid; -1 on timeout
    task automatic wait_out8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            tick();
            lat++;
        end
        if (!out_valid8) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({in_ready8, out_valid8, busy8} !== 3'b100 || product8 !== 16'h0) begin
            n_err++;
            $display("FAIL reset8: rdy/vld/busy=%b product=%h, want 100 / 0000",
                     {in_ready8, out_valid8, busy8}, product8);
        end
        n_cmp++;
        if ({in_ready2, out_valid2, busy2} !== 3'b100 || product2 !== 4'h0) begin
            n_err++;
            $display("FAIL reset2: rdy/vld/busy=%b product=%h, want 100 / 0",
                     {in_ready2, out_valid2, busy2}, product2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int busy_cnt;
        int lat;
        logic [15:0] exp;
        out_ready8 = 1'b1;
        send8(8'hA5, 8'h3C);
        n_cmp++;
        if (in_ready8 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_in_ready_drop: got %b want 0", in_ready8);
        end
        busy_cnt = 0;
        lat      = 0;
        while (!out_valid8 && lat < 100) begin
            if (busy8) busy_cnt++;
            tick();
            lat++;
        end
        n_cmp++;
        if (!out_valid8 || lat != 16) begin
            n_err++;
            $display("FAIL basic_latency: got %0d (valid=%b) want 16", lat, out_valid8);
        end
        n_cmp++;
        if (busy_cnt != 16) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d want 16", busy_cnt);
        end
        exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        n_cmp++;
        if (product8 !== exp || exp !== 16'h26AC) begin
            n_err++;
            $display("FAIL basic_product: got %h want %h", product8, 16'h26AC);
        end
        tick();
        n_cmp++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            n_err++;
            $display("FAIL basic_after_accept: vld=%b rdy=%b want 0/1", out_valid8, in_ready8);
        end
    endtask

    task automatic test_corners();
        logic [7:0] av [2];
        logic [7:0] bv [2];
        int lat;
        logic [15:0] exp;
        av[0] = 8'hFF; bv[0] = 8'hFF;
        av[1] = 8'h00; bv[1] = 8'hFF;
        out_ready8 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send8(av[k], bv[k]);
            wait_out8(lat);
            n_cmp++;
            if (lat != 16) begin
                n_err++;
                $display("FAIL corner%0d_latency: got %0d want 16", k, lat);
            end
            exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
            n_cmp++;
            if (product8 !== exp) begin
                n_err++;
                $display("FAIL corner%0d_product: got %h want %h", k, product8, exp);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] exp;
        out_ready8 = 1'b0;
        send8(8'h12, 8'h34);
        wait_out8(lat);
        n_cmp++;
        if (lat != 16) begin
            n_err++;
            $display("FAIL bp_latency: got %0d want 16", lat);
        end
        exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || product8 !== exp) begin
                n_err++;
                $display("FAIL bp_hold_c%0d: vld=%b rdy=%b product=%h want 1/0/%h",
                         c, out_valid8, in_ready8, product8, exp);
            end
            tick();
        end
        out_ready8 = 1'b1;
        tick();
        n_cmp++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || product8 !== 16'h03A8) begin
            n_err++;
            $display("FAIL bp_release: vld=%b rdy=%b product=%h want 0/1/03a8",
                     out_valid8, in_ready8, product8);
        end
    endtask

    task automatic test_input_ignore();
        int lat;
        logic [15:0] exp;
        out_ready8 = 1'b1;
        send8(8'h07, 8'h09);
        for (int c = 0; c < 8; c++) begin
            in_valid8 = 1'b1;
            a8 = (c % 2 == 0) ? 8'hFF : 8'h5A;
            b8 = (c % 2 == 0) ? 8'hFF : 8'hC3;
            n_cmp++;
            if (in_ready8 !== 1'b0) begin
                n_err++;
                $display("FAIL ignore_in_ready_c%0d: got %b want 0", c, in_ready8);
            end
            tick();
        end
        in_valid8 = 1'b0;
        wait_out8(lat);
        n_cmp++;
        if (lat != 8) begin
            n_err++;
            $display("FAIL ignore_latency: remaining %0d want 8", lat);
        end
        exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        n_cmp++;
        if (product8 !== exp || exp !== 16'h003F) begin
            n_err++;
            $display("FAIL ignore_product: got %h want 003f", product8);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [15:0] exp;
        out_ready8 = 1'b1;
        // Aborted operation: no scoreboard entry
        a8 = 8'hA5;
        b8 = 8'h3C;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({in_ready8, busy8, out_valid8} !== 3'b100 || product8 !== 16'h0) begin
            n_err++;
            $display("FAIL rstmid_state: rdy/busy/vld=%b product=%h want 100 / 0000",
                     {in_ready8, busy8, out_valid8}, product8);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid8) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL rstmid_no_valid: out_valid seen %0d cycles want 0", seen);
        end
        send8(8'h03, 8'h05);
        wait_out8(lat);
        exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        n_cmp++;
        if (lat != 16 || product8 !== exp || exp !== 16'h000F) begin
            n_err++;
            $display("FAIL rstmid_new_op: lat=%0d product=%h want 16 / 000f", lat, product8);
        end
        tick();
    endtask

    task automatic test_width2();
        logic [1:0] av [4];
        logic [1:0] bv [4];
        int acc_cyc [4];
        int k;
        int got;
        int cyc;
        int busy_cnt;
        logic [3:0] exp;
        av[0] = 2'd3; bv[0] = 2'd3;
        av[1] = 2'd2; bv[1] = 2'd1;
        av[2] = 2'd1; bv[2] = 2'd3;
        av[3] = 2'd2; bv[3] = 2'd2;
        out_ready2 = 1'b1;
        k = 0; got = 0; cyc = 0; busy_cnt = 0;
        while ((got < 4 || k < 4) && cyc < 60) begin
            if (busy2) busy_cnt++;
            if (out_valid2) begin
                exp = (q2.size() > 0) ? q2.pop_front() : 4'hx;
                n_cmp++;
                if (product2 !== exp) begin
                    n_err++;
                    $display("FAIL w2_product%0d: got %h want %h", got, product2, exp);
                end
                got++;
            end
            if (in_ready2) begin
                if (k < 4) begin
                    a2 = av[k];
                    b2 = bv[k];
                    in_valid2 = 1'b1;
                    q2.push_back(4'(av[k]) * 4'(bv[k]));
                    acc_cyc[k] = cyc;
                    k++;
                end else begin
                    in_valid2 = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        in_valid2 = 1'b0;
        n_cmp++;
        if (got != 4 || k != 4) begin
            n_err++;
            $display("FAIL w2_complete: results=%0d accepts=%0d want 4/4", got, k);
        end
        n_cmp++;
        if (busy_cnt != 4) begin
            n_err++;
            $display("FAIL w2_busy_cycles: got %0d want 4", busy_cnt);
        end
        for (int m = 1; m < 4; m++) begin
            n_cmp++;
            if (m < k && acc_cyc[m] - acc_cyc[m-1] != 3) begin
                n_err++;
                $display("FAIL w2_interval%0d: got %0d want 3", m, acc_cyc[m] - acc_cyc[m-1]);
            end
        end
        tick();
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        in_valid8  = 1'b0;
        a8         = '0;
        b8         = '0;
        out_ready8 = 1'b0;
        in_valid2  = 1'b0;
        a2         = '0;
        b2         = '0;
        out_ready2 = 1'b0;

        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_input_ignore();
        test_reset_mid();
        test_width2();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mul_2x2_seq_ctrl

`default_nettype wire
